// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared RV32I decode definitions: opcode constants, the instruction-format
// enum, the decoded bundle carried from decode to execute, and the
// opcode-to-format classifier.
// The bundle fields are RV32-wide. The decode stage casts these fields to its
// XLEN/RAW port widths.
// -----------------------------------------------------------------------------
package rv_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;

   // Only these two funct7 values exist for base-ISA R-type ops
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

   typedef struct packed {
      logic [31:0]        pc;
      logic [6:0]         opcode;
      logic [2:0]         funct3;
      logic [6:0]         funct7;
      logic [4:0]         rd;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic signed [31:0] imm;
      logic               illegal;
   } decode_bundle_t;

   function automatic fmt_e opcode_fmt(input logic [6:0] opc);
      fmt_e f;
      case (opc)
         OPC_LUI, OPC_AUIPC:                                         f = FMT_U;
         OPC_JAL:                                                    f = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM:   f = FMT_I;
         OPC_STORE:                                                  f = FMT_S;
         OPC_BRANCH:                                                 f = FMT_B;
         OPC_OP:                                                     f = FMT_R;
         default:                                                    f = FMT_X;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Bundles the fetch-side handshake, the execute-side decoded outputs and the
// writeback port of the decode stage.
//   master : environment side (fetch / execute / writeback drivers)
//   slave  : decode_stage side
// Signals: i_flush, i_valid/o_ready, i_instr, i_pc (fetch); o_valid/i_ready,
// o_pc, o_opcode, o_funct3, o_funct7, o_rd, o_rs1, o_rs2, o_imm, o_src1,
// o_src2, o_illegal (execute); i_rf_wen, i_rf_waddr, i_rf_wdata (writeback).
// -----------------------------------------------------------------------------
interface decode_stage_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32,
   parameter int NREG = 32
);
   localparam int RAW = $clog2(NREG);

   logic            i_flush;
   logic            i_valid;
   logic            o_ready;
   logic [ILEN-1:0] i_instr;
   logic [XLEN-1:0] i_pc;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_pc;
   logic [6:0]      o_opcode;
   logic [2:0]      o_funct3;
   logic [6:0]      o_funct7;
   logic [RAW-1:0]  o_rd;
   logic [RAW-1:0]  o_rs1;
   logic [RAW-1:0]  o_rs2;
   logic [XLEN-1:0] o_imm;
   logic [XLEN-1:0] o_src1;
   logic [XLEN-1:0] o_src2;
   logic            o_illegal;
   logic            i_rf_wen;
   logic [RAW-1:0]  i_rf_waddr;
   logic [XLEN-1:0] i_rf_wdata;

   modport master (
      output i_flush, i_valid, i_instr, i_pc, i_ready, i_rf_wen, i_rf_waddr, i_rf_wdata,
      input  o_ready, o_valid, o_pc, o_opcode, o_funct3, o_funct7, o_rd, o_rs1, o_rs2,
             o_imm, o_src1, o_src2, o_illegal
   );

   modport slave (
      input  i_flush, i_valid, i_instr, i_pc, i_ready, i_rf_wen, i_rf_waddr, i_rf_wdata,
      output o_ready, o_valid, o_pc, o_opcode, o_funct3, o_funct7, o_rd, o_rs1, o_rs2,
             o_imm, o_src1, o_src2, o_illegal
   );
endinterface

// File: rtl/rv_regfile.sv
// -----------------------------------------------------------------------------
// rv_regfile
// Architectural register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, cleared by synchronous active-low reset.
// Ports: clk, rstn, raddr1/rdata1, raddr2/rdata2, wen/waddr/wdata.
// -----------------------------------------------------------------------------
module rv_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int RAW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [RAW-1:0]  raddr1,
   input  logic [RAW-1:0]  raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic            wen,
   input  logic [RAW-1:0]  waddr,
   input  logic [XLEN-1:0] wdata
);
   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wen && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// RV32I decode pipeline stage between fetch and execute. Classifies the
// instruction format, extracts fields, builds the sign-extended immediate,
// reads rs1/rs2 from the internal register file and flags illegal encodings.
// The result is registered behind a valid/ready handshake. The stage supports
// stall (hold) and flush.
// Ports: clk, rstn (sync, active-low), bus (decode_stage_if.slave; see the
// interface file for the signal list).
// Build option: DECODE_WB_BYPASS_EN forwards same-cycle writeback data into
// src1/src2. Without it, the pre-write register value is used.
// -----------------------------------------------------------------------------
module decode_stage
   import rv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ILEN = 32,
   parameter int NREG = 32,
   localparam int RAW = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rstn,
   decode_stage_if.slave bus
);

   logic [31:0]     instr;
   fmt_e            fmt_p0;
   decode_bundle_t  dec_p0;
   logic [RAW-1:0]  rs1_idx_p0, rs2_idx_p0;
   logic [XLEN-1:0] rdata1_p0, rdata2_p0, src1_p0, src2_p0;
   logic            accept_p0;

   decode_bundle_t  bundle_p1;
   logic [XLEN-1:0] src1_p1, src2_p1;
   logic            vld_p1;

   function automatic logic signed [31:0] gen_imm(input fmt_e f, input logic [31:0] ins);
      logic signed [31:0] imm;
      case (f)
         FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
         FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         FMT_U:   imm = {ins[31:12], 12'b0};
         FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   // ---- stage p0: combinational decode and register read ----
   assign instr = bus.i_instr[31:0];

   always_comb begin
      fmt_p0         = opcode_fmt(instr[6:0]);
      dec_p0         = '0;
      dec_p0.pc      = 32'(bus.i_pc);
      dec_p0.opcode  = instr[6:0];
      dec_p0.funct3  = (fmt_p0 == FMT_U || fmt_p0 == FMT_J) ? 3'b000 : instr[14:12];
      // funct3 001/101 under OP-IMM are the shifts, where [31:25] selects SRLI/SRAI
      if (fmt_p0 == FMT_R || (instr[6:0] == OPC_OP_IMM && instr[13:12] == 2'b01))
         dec_p0.funct7 = instr[31:25];
      dec_p0.illegal = (fmt_p0 == FMT_X) || (instr[1:0] != 2'b11) ||
                       (fmt_p0 == FMT_R && instr[31:25] != F7_BASE && instr[31:25] != F7_ALT) ||
                       (instr[6:0] == OPC_JALR && instr[14:12] != 3'b000);
      if (!dec_p0.illegal) begin
         dec_p0.imm = gen_imm(fmt_p0, instr);
         if (fmt_p0 != FMT_S && fmt_p0 != FMT_B) dec_p0.rd  = instr[11:7];
         if (fmt_p0 != FMT_U && fmt_p0 != FMT_J) dec_p0.rs1 = instr[19:15];
         if (fmt_p0 == FMT_R || fmt_p0 == FMT_S || fmt_p0 == FMT_B) dec_p0.rs2 = instr[24:20];
      end
   end

   // Zeroed indices also zero the operands, because x0 reads as 0
   assign rs1_idx_p0 = RAW'(dec_p0.rs1);
   assign rs2_idx_p0 = RAW'(dec_p0.rs2);

   rv_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
      .clk    (clk),
      .rstn   (rstn),
      .raddr1 (rs1_idx_p0),
      .raddr2 (rs2_idx_p0),
      .rdata1 (rdata1_p0),
      .rdata2 (rdata2_p0),
      .wen    (bus.i_rf_wen),
      .waddr  (bus.i_rf_waddr),
      .wdata  (bus.i_rf_wdata)
   );

`ifdef DECODE_WB_BYPASS_EN
   assign src1_p0 = (bus.i_rf_wen && bus.i_rf_waddr == rs1_idx_p0 && rs1_idx_p0 != '0)
                    ? bus.i_rf_wdata : rdata1_p0;
   assign src2_p0 = (bus.i_rf_wen && bus.i_rf_waddr == rs2_idx_p0 && rs2_idx_p0 != '0)
                    ? bus.i_rf_wdata : rdata2_p0;
`else
   assign src1_p0 = rdata1_p0;
   assign src2_p0 = rdata2_p0;
`endif

   assign bus.o_ready = !vld_p1 || bus.i_ready;
   assign accept_p0   = bus.i_valid && bus.o_ready && !bus.i_flush;

   // ---- stage p1: output register ----
   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_p1    <= 1'b0;
         bundle_p1 <= '0;
         src1_p1   <= '0;
         src2_p1   <= '0;
      end else if (bus.i_flush) begin
         vld_p1 <= 1'b0;
      end else if (accept_p0) begin
         vld_p1    <= 1'b1;
         bundle_p1 <= dec_p0;
         src1_p1   <= src1_p0;
         src2_p1   <= src2_p0;
      end else if (bus.i_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.o_valid   = vld_p1;
   assign bus.o_pc      = XLEN'(bundle_p1.pc);
   assign bus.o_opcode  = bundle_p1.opcode;
   assign bus.o_funct3  = bundle_p1.funct3;
   assign bus.o_funct7  = bundle_p1.funct7;
   assign bus.o_rd      = RAW'(bundle_p1.rd);
   assign bus.o_rs1     = RAW'(bundle_p1.rs1);
   assign bus.o_rs2     = RAW'(bundle_p1.rs2);
   assign bus.o_imm     = XLEN'(bundle_p1.imm);
   assign bus.o_src1    = src1_p1;
   assign bus.o_src2    = src2_p1;
   assign bus.o_illegal = bundle_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed self-checking bench for decode_stage. Expected values are
// hand-derived from the instruction encodings. Build option seen by the bench:
// DECODE_WB_BYPASS_EN selects the expected same-cycle writeback result.
// -----------------------------------------------------------------------------
module tb_decode_stage;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   passes = 0;

   decode_stage_if #(.XLEN(32), .ILEN(32), .NREG(32)) bus ();

   decode_stage #(.XLEN(32), .ILEN(32), .NREG(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
      bus.i_valid = 1'b1;
      bus.i_instr = ins;
      bus.i_pc    = pc;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      checks++; if (bus.o_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.o_valid); else passes++;
      checks++; if (bus.o_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.o_ready); else passes++;
      checks++; if ({bus.o_pc, bus.o_imm, bus.o_src1, bus.o_src2} !== 128'h0) $display("FAIL rst_data: got %h want 0", {bus.o_pc, bus.o_imm, bus.o_src1, bus.o_src2}); else passes++;
      checks++; if ({bus.o_opcode, bus.o_funct3, bus.o_funct7, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_illegal} !== 33'h0) $display("FAIL rst_fields: got %h want 0", {bus.o_opcode, bus.o_funct3, bus.o_funct7, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_illegal}); else passes++;
      rstn = 1'b1;
   endtask

   task automatic test_itype();
      // addi x1,x0,-1
      offer(32'hFFF00093, 32'h0000_0100);
      tick();
      bus.i_valid = 1'b0;
      checks++; if (bus.o_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", bus.o_valid); else passes++;
      checks++; if (bus.o_imm !== 32'hFFFFFFFF) $display("FAIL addi_imm: got %h want ffffffff", bus.o_imm); else passes++;
      checks++; if ({bus.o_rd, bus.o_rs1, bus.o_rs2} !== {5'd1, 5'd0, 5'd0}) $display("FAIL addi_idx: got %h want %h", {bus.o_rd, bus.o_rs1, bus.o_rs2}, {5'd1, 5'd0, 5'd0}); else passes++;
      checks++; if ({bus.o_opcode, bus.o_funct3, bus.o_funct7, bus.o_illegal} !== {7'b0010011, 3'd0, 7'd0, 1'b0}) $display("FAIL addi_fields: got %h want %h", {bus.o_opcode, bus.o_funct3, bus.o_funct7, bus.o_illegal}, {7'b0010011, 3'd0, 7'd0, 1'b0}); else passes++;
      checks++; if (bus.o_pc !== 32'h0000_0100) $display("FAIL addi_pc: got %h want 00000100", bus.o_pc); else passes++;
      tick();
      checks++; if (bus.o_valid !== 1'b0) $display("FAIL addi_drain: got %b want 0", bus.o_valid); else passes++;
      // srai x1,x1,3 : shift carries funct7 0100000
      offer(32'h4030D093, 32'h0000_0104);
      tick();
      bus.i_valid = 1'b0;
      checks++; if ({bus.o_funct7, bus.o_funct3, bus.o_rs1} !== {7'b0100000, 3'b101, 5'd1}) $display("FAIL srai_fields: got %h want %h", {bus.o_funct7, bus.o_funct3, bus.o_rs1}, {7'b0100000, 3'b101, 5'd1}); else passes++;
      checks++; if (bus.o_imm !== 32'h00000403) $display("FAIL srai_imm: got %h want 00000403", bus.o_imm); else passes++;
      tick();
   endtask

   task automatic test_store();
      // load x1=0x100, x2=0x11111111 via writeback, then sw x2,8(x1)
      bus.i_rf_wen = 1'b1; bus.i_rf_waddr = 5'd1; bus.i_rf_wdata = 32'h0000_0100;
      tick();
      bus.i_rf_waddr = 5'd2; bus.i_rf_wdata = 32'h1111_1111;
      tick();
      bus.i_rf_wen = 1'b0;
      offer(32'h0020A423, 32'h0000_0108);
      tick();
      bus.i_valid = 1'b0;
      checks++; if (bus.o_imm !== 32'h8) $display("FAIL sw_imm: got %h want 00000008", bus.o_imm); else passes++;
      checks++; if ({bus.o_rd, bus.o_rs1, bus.o_rs2} !== {5'd0, 5'd1, 5'd2}) $display("FAIL sw_idx: got %h want %h", {bus.o_rd, bus.o_rs1, bus.o_rs2}, {5'd0, 5'd1, 5'd2}); else passes++;
      checks++; if (bus.o_funct3 !== 3'd2) $display("FAIL sw_funct3: got %0d want 2", bus.o_funct3); else passes++;
      checks++; if ({bus.o_src1, bus.o_src2} !== {32'h0000_0100, 32'h1111_1111}) $display("FAIL sw_src: got %h want %h", {bus.o_src1, bus.o_src2}, {32'h0000_0100, 32'h1111_1111}); else passes++;
      tick();
   endtask

   task automatic test_back_to_back();
      offer(32'hFE000EE3, 32'h0000_0200);  // beq x0,x0,-4
      tick();
      checks++; if ({bus.o_valid, bus.o_imm} !== {1'b1, 32'hFFFFFFFC}) $display("FAIL b2b_beq: got %h want %h", {bus.o_valid, bus.o_imm}, {1'b1, 32'hFFFFFFFC}); else passes++;
      checks++; if ({bus.o_rd, bus.o_rs1, bus.o_rs2} !== 15'd0) $display("FAIL b2b_beq_idx: got %h want 0", {bus.o_rd, bus.o_rs1, bus.o_rs2}); else passes++;
      offer(32'h001000EF, 32'h0000_0204);  // jal x1,+2048
      tick();
      checks++; if ({bus.o_valid, bus.o_imm, bus.o_rd} !== {1'b1, 32'h00000800, 5'd1}) $display("FAIL b2b_jal: got %h want %h", {bus.o_valid, bus.o_imm, bus.o_rd}, {1'b1, 32'h00000800, 5'd1}); else passes++;
      checks++; if (bus.o_pc !== 32'h0000_0204) $display("FAIL b2b_jal_pc: got %h want 00000204", bus.o_pc); else passes++;
      offer(32'h123452B7, 32'h0000_0208);  // lui x5,0x12345
      tick();
      bus.i_valid = 1'b0;
      checks++; if ({bus.o_valid, bus.o_imm, bus.o_rd} !== {1'b1, 32'h12345000, 5'd5}) $display("FAIL b2b_lui: got %h want %h", {bus.o_valid, bus.o_imm, bus.o_rd}, {1'b1, 32'h12345000, 5'd5}); else passes++;
      checks++; if ({bus.o_funct3, bus.o_rs1} !== 8'd0) $display("FAIL b2b_lui_zero: got %h want 0", {bus.o_funct3, bus.o_rs1}); else passes++;
      tick();
      checks++; if (bus.o_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", bus.o_valid); else passes++;
   endtask

   task automatic test_stall_flush();
      bus.i_ready = 1'b0;
      offer(32'h123452B7, 32'h0000_0300);
      tick();
      offer(32'hFFF00093, 32'h0000_0304);  // must not be taken while stalled
      for (int c = 0; c < 3; c++) begin
         checks++; if (bus.o_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", bus.o_ready); else passes++;
         checks++; if ({bus.o_valid, bus.o_imm, bus.o_rd, bus.o_pc} !== {1'b1, 32'h12345000, 5'd5, 32'h0000_0300}) $display("FAIL stall_hold: got %h want %h", {bus.o_valid, bus.o_imm, bus.o_rd, bus.o_pc}, {1'b1, 32'h12345000, 5'd5, 32'h0000_0300}); else passes++;
         tick();
      end
      checks++; if ({bus.o_valid, bus.o_imm, bus.o_opcode} !== {1'b1, 32'h12345000, 7'b0110111}) $display("FAIL stall_hold_end: got %h want %h", {bus.o_valid, bus.o_imm, bus.o_opcode}, {1'b1, 32'h12345000, 7'b0110111}); else passes++;
      bus.i_flush = 1'b1;
      tick();
      bus.i_flush = 1'b0;
      bus.i_valid = 1'b0;
      checks++; if (bus.o_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.o_valid); else passes++;
      checks++; if (bus.o_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", bus.o_ready); else passes++;
      bus.i_ready = 1'b1;
      // flush while offering with ready high: nothing is accepted
      offer(32'hFFF00093, 32'h0000_0308);
      bus.i_flush = 1'b1;
      tick();
      bus.i_flush = 1'b0;
      bus.i_valid = 1'b0;
      checks++; if (bus.o_valid !== 1'b0) $display("FAIL flush_drop: got %b want 0", bus.o_valid); else passes++;
   endtask

   task automatic test_bypass();
      logic [31:0] exp_src;
`ifdef DECODE_WB_BYPASS_EN
      exp_src = 32'hDEADBEEF;
`else
      exp_src = 32'h0;
`endif
      bus.i_rf_wen = 1'b1; bus.i_rf_waddr = 5'd3; bus.i_rf_wdata = 32'hDEADBEEF;
      offer(32'h00318233, 32'h0000_0400);  // add x4,x3,x3
      tick();
      bus.i_rf_wen = 1'b0;
      checks++; if ({bus.o_src1, bus.o_src2} !== {exp_src, exp_src}) $display("FAIL byp_same_cycle: got %h want %h", {bus.o_src1, bus.o_src2}, {exp_src, exp_src}); else passes++;
      checks++; if ({bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_funct7} !== {5'd4, 5'd3, 5'd3, 7'd0}) $display("FAIL byp_idx: got %h want %h", {bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_funct7}, {5'd4, 5'd3, 5'd3, 7'd0}); else passes++;
      tick();  // write landed; same instruction now reads the new value
      bus.i_valid = 1'b0;
      checks++; if ({bus.o_src1, bus.o_src2} !== {32'hDEADBEEF, 32'hDEADBEEF}) $display("FAIL byp_after_write: got %h want %h", {bus.o_src1, bus.o_src2}, {32'hDEADBEEF, 32'hDEADBEEF}); else passes++;
      // x0 write: ignored, never forwarded
      bus.i_rf_wen = 1'b1; bus.i_rf_waddr = 5'd0; bus.i_rf_wdata = 32'h12345678;
      offer(32'h00000233, 32'h0000_0404);  // add x4,x0,x0
      tick();
      bus.i_rf_wen = 1'b0;
      checks++; if ({bus.o_src1, bus.o_src2} !== 64'h0) $display("FAIL x0_same_cycle: got %h want 0", {bus.o_src1, bus.o_src2}); else passes++;
      tick();
      bus.i_valid = 1'b0;
      checks++; if ({bus.o_src1, bus.o_src2} !== 64'h0) $display("FAIL x0_after_write: got %h want 0", {bus.o_src1, bus.o_src2}); else passes++;
      tick();
   endtask

   task automatic test_illegal();
      offer(32'h00000000, 32'h0000_0500);
      tick();
      checks++; if ({bus.o_valid, bus.o_illegal, bus.o_imm} !== {1'b1, 1'b1, 32'h0}) $display("FAIL ill_zero: got %h want %h", {bus.o_valid, bus.o_illegal, bus.o_imm}, {1'b1, 1'b1, 32'h0}); else passes++;
      offer(32'h02318233, 32'h0000_0504);  // funct7 0000001 on OP; x3 holds DEADBEEF
      tick();
      checks++; if ({bus.o_illegal, bus.o_rd, bus.o_rs1, bus.o_rs2} !== {1'b1, 15'd0}) $display("FAIL ill_r_f7: got %h want %h", {bus.o_illegal, bus.o_rd, bus.o_rs1, bus.o_rs2}, {1'b1, 15'd0}); else passes++;
      checks++; if ({bus.o_src1, bus.o_src2} !== 64'h0) $display("FAIL ill_src: got %h want 0", {bus.o_src1, bus.o_src2}); else passes++;
      offer(32'h000090E7, 32'h0000_0508);  // jalr with funct3 001
      tick();
      checks++; if (bus.o_illegal !== 1'b1) $display("FAIL ill_jalr_f3: got %b want 1", bus.o_illegal); else passes++;
      offer(32'h000080E7, 32'h0000_050C);  // jalr x1,0(x1)
      tick();
      bus.i_valid = 1'b0;
      checks++; if ({bus.o_illegal, bus.o_rd, bus.o_rs1, bus.o_imm} !== {1'b0, 5'd1, 5'd1, 32'h0}) $display("FAIL jalr_ok: got %h want %h", {bus.o_illegal, bus.o_rd, bus.o_rs1, bus.o_imm}, {1'b0, 5'd1, 5'd1, 32'h0}); else passes++;
      offer(32'hFFF00090, 32'h0000_0510);  // addi with instr[1:0]=00
      tick();
      bus.i_valid = 1'b0;
      checks++; if ({bus.o_illegal, bus.o_imm} !== {1'b1, 32'h0}) $display("FAIL ill_low_bits: got %h want %h", {bus.o_illegal, bus.o_imm}, {1'b1, 32'h0}); else passes++;
      tick();
   endtask

   task automatic test_reset_mid_stall();
      bus.i_ready = 1'b0;
      offer(32'h0020A423, 32'h0000_0600);  // sw x2,8(x1): x1=0x100, x2=0x11111111
      tick();
      checks++; if ({bus.o_valid, bus.o_src1, bus.o_src2} !== {1'b1, 32'h0000_0100, 32'h1111_1111}) $display("FAIL rms_pre: got %h want %h", {bus.o_valid, bus.o_src1, bus.o_src2}, {1'b1, 32'h0000_0100, 32'h1111_1111}); else passes++;
      tick();
      rstn = 1'b0;
      tick();
      checks++; if ({bus.o_valid, bus.o_ready} !== 2'b01) $display("FAIL rms_hs: got %b want 01", {bus.o_valid, bus.o_ready}); else passes++;
      checks++; if ({bus.o_pc, bus.o_imm, bus.o_src1, bus.o_src2} !== 128'h0) $display("FAIL rms_data: got %h want 0", {bus.o_pc, bus.o_imm, bus.o_src1, bus.o_src2}); else passes++;
      checks++; if ({bus.o_opcode, bus.o_funct3, bus.o_funct7, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_illegal} !== 33'h0) $display("FAIL rms_fields: got %h want 0", {bus.o_opcode, bus.o_funct3, bus.o_funct7, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_illegal}); else passes++;
      rstn = 1'b1;
      bus.i_ready = 1'b1;
      tick();  // sw still offered: accepted against the cleared register file
      bus.i_valid = 1'b0;
      checks++; if ({bus.o_valid, bus.o_src1, bus.o_src2} !== {1'b1, 64'h0}) $display("FAIL rms_rf_clear: got %h want %h", {bus.o_valid, bus.o_src1, bus.o_src2}, {1'b1, 64'h0}); else passes++;
      offer(32'h00318233, 32'h0000_0604);  // x3 was DEADBEEF before reset
      tick();
      bus.i_valid = 1'b0;
      checks++; if ({bus.o_src1, bus.o_src2} !== 64'h0) $display("FAIL rms_x3_clear: got %h want 0", {bus.o_src1, bus.o_src2}); else passes++;
      tick();
   endtask

   initial begin
      bus.i_flush    = 1'b0;
      bus.i_valid    = 1'b0;
      bus.i_instr    = '0;
      bus.i_pc       = '0;
      bus.i_ready    = 1'b1;
      bus.i_rf_wen   = 1'b0;
      bus.i_rf_waddr = '0;
      bus.i_rf_wdata = '0;
      test_reset();
      test_itype();
      test_store();
      test_back_to_back();
      test_stall_flush();
      test_bypass();
      test_illegal();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised RV32I decode pipeline stage between fetch and execute.
- Decodes all base formats (R/I/S/B/U/J) and generates the sign-extended immediate.
- Reads rs1/rs2 from an internal register file; flags illegal encodings.
- Registers results behind a valid/ready handshake with stall and flush support.

Parameters:
- XLEN, 32, datapath and register width.
- ILEN, 32, instruction width; only 32 supported; bits above [31:0] are ignored.
- NREG, 32, architectural register count; index width RAW = $clog2(NREG).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- i_flush  in  1  drop the held output and any instruction offered this cycle
- i_valid  in  1  fetch offers an instruction
- o_ready  out  1  stage can accept
- i_instr  in  ILEN  instruction word
- i_pc  in  XLEN  PC of i_instr
- o_valid  out  1  decoded bundle valid
- i_ready  in  1  execute accepts the bundle
- o_pc  out  XLEN  registered PC
- o_opcode  out  7  opcode field
- o_funct3  out  3  funct3, zeroed for U/J
- o_funct7  out  7  funct7 for R-type; instr[31:25] for I-type shifts; else 0
- o_rd  out  RAW  rd index, 0 for S/B
- o_rs1  out  RAW  rs1 index, 0 for U/J
- o_rs2  out  RAW  rs2 index, 0 unless R/S/B
- o_imm  out  XLEN  sign-extended immediate
- o_src1  out  XLEN  rs1 read data
- o_src2  out  XLEN  rs2 read data
- o_illegal  out  1  unsupported encoding
- i_rf_wen  in  1  writeback enable
- i_rf_waddr  in  RAW  writeback index
- i_rf_wdata  in  XLEN  writeback data

Behaviour:
- Reset: all outputs and the register file are 0; o_valid=0.
- Handshake:
  - o_ready = !o_valid || i_ready.
  - Accept occurs when i_valid && o_ready && !i_flush.
  - On accept, all output registers load next cycle, with o_valid=1: latency 1 cycle, throughput 1/cycle.
  - If o_valid && i_ready && no accept, o_valid clears.
  - If o_valid && !i_ready (stall), every output holds, bit-stable.
- Flush: i_flush clears o_valid next cycle and has priority over accept and hold; other output registers may keep stale data.
- Opcode classes:
  - LUI 0110111, AUIPC 0010111: U-type.
  - JAL 1101111: J-type.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111, SYSTEM 1110011: I-type.
  - STORE 0100011: S-type.
  - BRANCH 1100011: B-type.
  - OP 0110011: R-type.
- Immediates (XLEN-wide, sign bit instr[31]):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: 0.
- Illegal: o_illegal=1 for any of:
  - unlisted opcode;
  - instr[1:0] != 2'b11;
  - R-type funct7 not in {0000000, 0100000};
  - JALR funct3 != 000.
- When illegal: imm, indices, src1 and src2 are 0; the bundle still flows (o_valid=1). Illegal is not a simulation error.
- Register file:
  - Combinational read of rs1/rs2 at accept; synchronous write on clk.
  - x0 reads 0; writes to x0 are ignored.
  - Writeback continues during stall and flush.
  - Register contents hold across flush; only rstn clears them.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: if i_rf_wen && i_rf_waddr==rsN && rsN!=0 in the accept cycle, srcN takes i_rf_wdata.
- Undefined: srcN takes the pre-write register value; the hazard is left to the hazard unit.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams;
  - format enum fmt_e {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X};
  - packed struct decode_bundle_t (pc, opcode, funct3, funct7, rd, rs1, rs2, imm, illegal).
- Sub-module rv_regfile (params XLEN, NREG): 2 combinational read ports, 1 synchronous write port, x0 hardwired to zero, synchronous reset clear.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_rd=1, o_rs1=0, o_funct3=0, o_illegal=0.
- sw x2,8(x1) (0x0020A423) -> o_imm=8, o_rs1=1, o_rs2=2, o_rd=0, o_funct3=2.
- Back-to-back stream of three instructions:
  - beq x0,x0,-4 (0xFE000EE3) -> o_imm=0xFFFFFFFC.
  - jal x1,+2048 (0x001000EF) -> o_imm=0x00000800, o_rd=1.
  - lui x5,0x12345 (0x123452B7) -> o_imm=0x12345000, o_rd=5.
- Stall then flush:
  - Hold i_ready=0 for 3 cycles with o_valid=1 -> o_ready=0 and all outputs stable.
  - Then assert i_flush for 1 cycle -> o_valid=0 next cycle.
- Bypass: writeback x3=0xDEADBEEF in the same cycle add x4,x3,x3 (0x00318233) is accepted:
  - With DECODE_WB_BYPASS_EN -> o_src1=o_src2=0xDEADBEEF.
  - Without it -> old x3 value (0 after reset).
  - Writes to x0 -> reads remain 0.
- Illegal and reset:
  - Instruction 0x00000000 -> o_illegal=1, o_imm=0, o_valid=1.
  - rstn low mid-stall -> o_valid=0, all outputs 0, register file zero.
